v_lane_mem_sequencer: RTL and testbench

//  Memory-side controller for one vector lane. Accepts load/store transfer commands and moves
//  `len` elements between a memory stream port and the lane's load FIFO (write side) or store

---
 rtl/v_lane_mem_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_v_lane_mem_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/v_lane_mem_sequencer.sv
// Memory-side transfer sequencer for one vector lane: streams loads into the lane FIFO and drains stores through a 2-entry skid.
// Optional watchdog abort is compiled in with `define V_SEQ_TIMEOUT_EN.
module v_lane_mem_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int VECTOR_LENGTH  = 1024,
    parameter int VL_W           = $clog2(VECTOR_LENGTH / DATA_WIDTH) + 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_store_i,
    input  logic [VL_W-1:0]       cmd_len_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  mem_rready_o,
    output logic                  mem_wvalid_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_wready_i,
    output logic                  load_fifo_we_o,
    output logic [DATA_WIDTH-1:0] load_fifo_wdata_o,
    input  logic                  load_fifo_almostfull_i,
    output logic                  store_fifo_re_o,
    input  logic [DATA_WIDTH-1:0] store_fifo_rdata_i,
    input  logic                  store_fifo_empty_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int              VL_MAX   = VECTOR_LENGTH / DATA_WIDTH;
    localparam logic [VL_W-1:0] VL_MAX_V = VL_W'(VL_MAX);
    localparam logic [VL_W-1:0] ONE_V    = VL_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [VL_W-1:0]       len_q, len_d;
    logic [VL_W-1:0]       rem_q, rem_d;
    logic [VL_W-1:0]       wr_cnt_q, wr_cnt_d;
    logic [1:0]            occ_q, occ_d;
    logic                  infl_q, infl_d;
    logic [DATA_WIDTH-1:0] skid0_q, skid1_q;

    logic [VL_W-1:0]       len_clamped;
    logic                  pop;
    logic                  elem;
    logic [2:0]            skid_load;

`ifdef V_SEQ_TIMEOUT_EN
    localparam int             WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            rem_q    <= '0;
            wr_cnt_q <= '0;
            occ_q    <= '0;
            infl_q   <= 1'b0;
`ifdef V_SEQ_TIMEOUT_EN
            wd_q     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            wr_cnt_q <= wr_cnt_d;
            occ_q    <= occ_d;
            infl_q   <= infl_d;
`ifdef V_SEQ_TIMEOUT_EN
            wd_q     <= wd_d;
            err_q    <= err_d;
`endif
        end
    end

    // Skid data is only meaningful under occ_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (infl_q) begin
            if (occ_q == 2'd0 || (occ_q == 2'd1 && pop)) begin
                skid0_q <= store_fifo_rdata_i;
            end else if (occ_q == 2'd1) begin
                skid1_q <= store_fifo_rdata_i;
            end else begin
                skid0_q <= skid1_q;
                skid1_q <= store_fifo_rdata_i;
            end
        end else if (pop) begin
            skid0_q <= skid1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rem_d    = rem_q;
        wr_cnt_d = wr_cnt_q;
        infl_d   = 1'b0;

        cmd_ready_o       = (state_q == S_IDLE);
        busy_o            = (state_q != S_IDLE);
        done_o            = 1'b0;
        err_o             = 1'b0;
        mem_rready_o      = 1'b0;
        load_fifo_we_o    = 1'b0;
        load_fifo_wdata_o = '0;
        store_fifo_re_o   = 1'b0;
        elem              = 1'b0;

        len_clamped = (cmd_len_i > VL_MAX_V) ? VL_MAX_V : cmd_len_i;

        mem_wvalid_o = (state_q == S_STORE) && (occ_q != 2'd0);
        mem_wdata_o  = mem_wvalid_o ? skid0_q : '0;
        pop          = mem_wvalid_o & mem_wready_i;

        // Slots the skid will hold next cycle; a same-cycle pop frees one, which keeps 1 element/cycle.
        skid_load = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    len_d    = len_clamped;
                    rem_d    = len_clamped;
                    wr_cnt_d = '0;
                    if (len_clamped == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = cmd_store_i ? S_STORE : S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                mem_rready_o = (rem_q != '0) && !load_fifo_almostfull_i;
                if (mem_rvalid_i && mem_rready_o) begin
                    load_fifo_we_o    = 1'b1;
                    load_fifo_wdata_o = mem_rdata_i;
                    rem_d             = rem_q - ONE_V;
                    elem              = 1'b1;
                    if (rem_q == ONE_V) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_STORE: begin
                store_fifo_re_o = (rem_q != '0) && !store_fifo_empty_i && (skid_load < 3'd2);
                if (store_fifo_re_o) begin
                    rem_d = rem_q - ONE_V;
                end
                infl_d = store_fifo_re_o;
                if (pop) begin
                    wr_cnt_d = wr_cnt_q + ONE_V;
                    elem     = 1'b1;
                    if (wr_cnt_q + ONE_V == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        occ_d = skid_load[1:0];

`ifdef V_SEQ_TIMEOUT_EN
        wd_d  = wd_q;
        err_d = err_q;
        err_o = (state_q == S_DONE) && err_q;
        if (state_q == S_IDLE) begin
            wd_d  = '0;
            err_d = 1'b0;
        end else if (state_q == S_LOAD || state_q == S_STORE) begin
            if (elem) begin
                wd_d = '0;
            end else if (wd_q == WD_LIM) begin
                state_d = S_DONE;
                err_d   = 1'b1;
                occ_d   = '0;
                infl_d  = 1'b0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_v_lane_mem_sequencer.sv
// Scoreboard bench for v_lane_mem_sequencer: expected element streams are queued at command issue and popped at each write.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_v_lane_mem_sequencer;

    localparam int DW  = 32;
    localparam int VL  = 1024;
    localparam int VLW = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic           cmd_valid_i, cmd_ready_o, cmd_store_i;
    logic [VLW-1:0] cmd_len_i;
    logic           mem_rvalid_i, mem_rready_o;
    logic [DW-1:0]  mem_rdata_i;
    logic           mem_wvalid_o, mem_wready_i;
    logic [DW-1:0]  mem_wdata_o;
    logic           load_fifo_we_o, load_fifo_almostfull_i;
    logic [DW-1:0]  load_fifo_wdata_o;
    logic           store_fifo_re_o, store_fifo_empty_i;
    logic [DW-1:0]  store_fifo_rdata_i;
    logic           busy_o, done_o, err_o;

    always #5 clk = ~clk;

    v_lane_mem_sequencer #(.DATA_WIDTH(DW), .VECTOR_LENGTH(VL)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_store_i(cmd_store_i), .cmd_len_i(cmd_len_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_rready_o(mem_rready_o),
        .mem_wvalid_o(mem_wvalid_o), .mem_wdata_o(mem_wdata_o), .mem_wready_i(mem_wready_i),
        .load_fifo_we_o(load_fifo_we_o), .load_fifo_wdata_o(load_fifo_wdata_o),
        .load_fifo_almostfull_i(load_fifo_almostfull_i),
        .store_fifo_re_o(store_fifo_re_o), .store_fifo_rdata_i(store_fifo_rdata_i),
        .store_fifo_empty_i(store_fifo_empty_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    logic [DW-1:0] ldq[$];
    logic [DW-1:0] stq[$];
    logic [DW-1:0] lbase, sbase, exp_v;

    int mode, tcyc;
    int we_cnt, re_cnt, wr_cnt, done_cnt, err_cnt, ld_beats, rd_idx, af_cyc;
    int stall_viol, max_out, acc_cyc, done_cyc, last_we_cyc, first_wr_cyc, last_wr_cyc;
    logic re_prev, cmd_pend;

    task automatic clear_stats();
        we_cnt = 0; re_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0;
        ld_beats = 0; rd_idx = 0; af_cyc = 0; stall_viol = 0; max_out = 0;
        acc_cyc = -1; done_cyc = -1; last_we_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
        re_prev = 1'b0; cmd_pend = 1'b0;
        ldq.delete(); stq.delete();
    endtask

    task automatic cycle();
        @(negedge clk);
        cmd_valid_i = cmd_pend;
        if (re_prev) begin
            store_fifo_rdata_i = sbase + rd_idx;
            rd_idx++;
        end else begin
            store_fifo_rdata_i = 32'hDEAD_BEEF;
        end
        mem_rvalid_i = 1'b0; load_fifo_almostfull_i = 1'b0; mem_wready_i = 1'b0; store_fifo_empty_i = 1'b1;
        case (mode)
            0: mem_rvalid_i = 1'b1;
            1: begin
                mem_rvalid_i = 1'b1;
                if (ld_beats >= 3 && af_cyc < 5) begin
                    load_fifo_almostfull_i = 1'b1;
                    af_cyc++;
                end
            end
            2: begin mem_wready_i = 1'b1; store_fifo_empty_i = 1'b0; end
            3: begin mem_wready_i = (tcyc % 2 == 0); store_fifo_empty_i = 1'b0; end
            default: ;
        endcase
        mem_rdata_i = lbase + ld_beats;
        #1;
        if (cmd_valid_i && cmd_ready_o) begin
            acc_cyc = tcyc;
            cmd_pend = 1'b0;
        end
        if (load_fifo_we_o) begin
            if (ldq.size() == 0) check("ld_extra", 1, 0);
            else begin
                exp_v = ldq.pop_front();
                check("ld_data", load_fifo_wdata_o, exp_v);
            end
            ld_beats++; we_cnt++; last_we_cyc = tcyc;
        end
        if (load_fifo_almostfull_i && mem_rready_o) stall_viol++;
        re_prev = store_fifo_re_o;
        if (store_fifo_re_o) re_cnt++;
        if (mem_wvalid_o && mem_wready_i) begin
            if (stq.size() == 0) check("st_extra", 1, 0);
            else begin
                exp_v = stq.pop_front();
                check("st_data", mem_wdata_o, exp_v);
            end
            if (wr_cnt == 0) first_wr_cyc = tcyc;
            wr_cnt++; last_wr_cyc = tcyc;
        end
        if (re_cnt - wr_cnt > max_out) max_out = re_cnt - wr_cnt;
        if (done_o) begin done_cnt++; done_cyc = tcyc; end
        if (err_o) err_cnt++;
        tcyc++;
    endtask

    task automatic start_cmd(input logic st, input int len);
        int n;
        int k;
        n = (len > 32) ? 32 : len;
        for (int i = 0; i < n; i++) begin
            if (st) stq.push_back(sbase + i);
            else    ldq.push_back(lbase + i);
        end
        cmd_store_i = st;
        cmd_len_i   = VLW'(len);
        cmd_pend    = 1'b1;
        k = 0;
        while (cmd_pend && k < 20) begin cycle(); k++; end
        if (cmd_pend) begin
            check("accept", 0, 1);
            cmd_pend = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin cycle(); k++; end
        if (done_cnt == 0) check("done_wait", 0, 1);
        repeat (3) cycle();
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid_i = 0; cmd_store_i = 0; cmd_len_i = '0;
        mem_rvalid_i = 0; mem_rdata_i = '0; mem_wready_i = 0;
        load_fifo_almostfull_i = 0; store_fifo_rdata_i = '0; store_fifo_empty_i = 1;
        tcyc = 0; mode = 4; lbase = '0; sbase = '0;
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_ctl", {cmd_ready_o, mem_rready_o, mem_wvalid_o, load_fifo_we_o, store_fifo_re_o, busy_o, done_o, err_o}, 8'b1000_0000);
        check("rst_wdata", mem_wdata_o, 0);
        reset = 1'b0;

        // load len=8, memory always valid
        clear_stats(); mode = 0; lbase = 32'h1000;
        start_cmd(1'b0, 8); wait_done(40);
        check("ld8_we", we_cnt, 8);
        check("ld8_q", ldq.size(), 0);
        check("ld8_done", done_cnt, 1);
        check("ld8_lat", done_cyc - last_we_cyc, 1);
        check("ld8_err", err_cnt, 0);

        // load len=8 with almost-full stall
        clear_stats(); mode = 1; lbase = 32'h2000;
        start_cmd(1'b0, 8); wait_done(60);
        check("stall_we", we_cnt, 8);
        check("stall_rready", stall_viol, 0);
        check("stall_len", af_cyc, 5);
        check("stall_q", ldq.size(), 0);
        check("stall_done", done_cnt, 1);

        // store len=32, memory always ready
        clear_stats(); mode = 2; sbase = 32'h3000;
        start_cmd(1'b1, 32); wait_done(100);
        check("st32_wr", wr_cnt, 32);
        check("st32_re", re_cnt, 32);
        check("st32_b2b", last_wr_cyc - first_wr_cyc, 31);
        check("st32_q", stq.size(), 0);
        check("st32_done", done_cnt, 1);

        // store len=4, memory ready toggling
        clear_stats(); mode = 3; sbase = 32'h4000;
        start_cmd(1'b1, 4); wait_done(60);
        check("st4_skid", max_out <= 2, 1);
        check("st4_wr", wr_cnt, 4);
        check("st4_q", stq.size(), 0);
        check("st4_done", done_cnt, 1);

        // zero length: straight to done, no strobes
        clear_stats(); mode = 0; lbase = 32'h5000;
        start_cmd(1'b0, 0); wait_done(20);
        check("len0_lat", done_cyc - acc_cyc, 1);
        check("len0_we", we_cnt, 0);
        check("len0_re", re_cnt, 0);

        // over-length command clamps to 32 elements
        clear_stats(); mode = 0; lbase = 32'h6000;
        start_cmd(1'b0, 40); wait_done(80);
        check("clamp_we", we_cnt, 32);
        check("clamp_q", ldq.size(), 0);

        // reset in the middle of a store burst
        clear_stats(); mode = 3; sbase = 32'h7000;
        start_cmd(1'b1, 32);
        repeat (6) cycle();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_ctl", {cmd_ready_o, mem_rready_o, mem_wvalid_o, load_fifo_we_o, store_fifo_re_o, busy_o, done_o, err_o}, 8'b1000_0000);
        check("mid_rst_wdata", mem_wdata_o, 0);
        check("mid_rst_ldata", load_fifo_wdata_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // recovery after reset
        clear_stats(); mode = 0; lbase = 32'h8000;
        start_cmd(1'b0, 3); wait_done(30);
        check("post_we", we_cnt, 3);
        check("post_done", done_cnt, 1);
        check("post_q", ldq.size(), 0);

`ifdef V_SEQ_TIMEOUT_EN
        // starved load aborts through the watchdog
        clear_stats(); mode = 4; lbase = 32'h9000;
        start_cmd(1'b0, 4); wait_done(400);
        check("wd_err", err_cnt, 1);
        check("wd_lat", done_cyc - acc_cyc, 257);
        check("wd_ready", cmd_ready_o, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
